// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Brief    : Multi-cycle unsigned MUL/DIVU/REMU sequencer borrowing the
//             core's shared combinational ALU for every add/sub/compare.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op_sel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_op,
    input  logic [XLEN-1:0] alu_res
);

    localparam int                c_CW       = $clog2(XLEN);
    localparam logic [c_CW-1:0]   c_LAST     = c_CW'(XLEN - 1);

    localparam logic [1:0]        c_OP_MUL   = 2'd0;
    localparam logic [1:0]        c_OP_DIVU  = 2'd1;
    localparam logic [1:0]        c_OP_REMU  = 2'd2;

    localparam logic [4:0]        c_ALU_PASS = 5'd0;
    localparam logic [4:0]        c_ALU_ADD  = 5'd1;
    localparam logic [4:0]        c_ALU_SUB  = 5'd5;
    localparam logic [4:0]        c_ALU_SLTU = 5'd6;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_STEP = 3'd1,
        S_DIV_CMP  = 3'd2,
        S_DIV_SUB  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // r_acc doubles as the divide remainder, r_mp as the quotient
    logic [XLEN-1:0]   r_acc;
    logic [XLEN-1:0]   r_mc;
    logic [XLEN-1:0]   r_mp;
    logic [XLEN-1:0]   r_dvs;
    logic [XLEN-1:0]   r_rs;
    logic              r_take;
    logic [1:0]        r_op;
    logic [c_CW-1:0]   r_cnt;
    logic [XLEN-1:0]   r_result;

    logic [XLEN-1:0]   w_rs;
    logic              w_c;
    logic [XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]   w_rem_nxt;
    logic [XLEN-1:0]   w_quo_nxt;

    assign w_rs      = {r_acc[XLEN-2:0], r_mp[XLEN-1]};
    assign w_c       = r_acc[XLEN-1];
    assign w_acc_nxt = r_mp[0] ? alu_res : r_acc;
    assign w_rem_nxt = r_take ? alu_res : r_rs;
    assign w_quo_nxt = r_mp | {{(XLEN-1){1'b0}}, r_take};
    assign result    = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = c_ALU_PASS;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    case (op_sel)
                        c_OP_MUL:  w_state_nxt = S_MUL_STEP;
                        c_OP_DIVU,
                        c_OP_REMU: w_state_nxt = (b == '0) ? S_DONE : S_DIV_CMP;
                        default:   w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_MUL_STEP: begin
                alu_a  = r_acc;
                alu_b  = r_mc;
                alu_op = c_ALU_ADD;
                if (r_cnt == c_LAST) w_state_nxt = S_DONE;
            end
            S_DIV_CMP: begin
                alu_a       = w_rs;
                alu_b       = r_dvs;
                alu_op      = c_ALU_SLTU;
                w_state_nxt = S_DIV_SUB;
            end
            S_DIV_SUB: begin
                alu_a       = r_rs;
                alu_b       = r_dvs;
                alu_op      = c_ALU_SUB;
                w_state_nxt = (r_cnt == c_LAST) ? S_DONE : S_DIV_CMP;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mc     <= '0;
            r_mp     <= '0;
            r_dvs    <= '0;
            r_rs     <= '0;
            r_take   <= 1'b0;
            r_op     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= op_sel;
                        r_cnt <= '0;
                        r_acc <= '0;
                        r_mc  <= a;
                        r_dvs <= b;
                        r_mp  <= (op_sel == c_OP_MUL) ? b : a;
                        case (op_sel)
                            c_OP_MUL: ;
                            c_OP_DIVU: if (b == '0) r_result <= '1;
                            c_OP_REMU: if (b == '0) r_result <= a;
                            default:   r_result <= '0;
                        endcase
                    end
                end
                S_MUL_STEP: begin
                    r_acc <= w_acc_nxt;
                    r_mc  <= r_mc << 1;
                    r_mp  <= r_mp >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) r_result <= w_acc_nxt;
                end
                S_DIV_CMP: begin
                    // rem[31] set means the true 33-bit partial remainder exceeds any divisor
                    r_rs   <= w_rs;
                    r_take <= w_c | (alu_res == '0);
                    r_mp   <= r_mp << 1;
                end
                S_DIV_SUB: begin
                    r_acc <= w_rem_nxt;
                    r_mp  <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_result <= (r_op == c_OP_DIVU) ? w_quo_nxt : w_rem_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
